// File: rtl/move_predict_seq.sv
// Multi-cycle move evaluator: collision check, merge on blocked down move, row compaction.
// Optional running score accumulator built only when SCORE_ACC_EN is defined.
module move_predict_seq #(
   parameter int FIELD_W = 20,
   parameter int FIELD_H = 20,
   parameter int BLK     = 4,
   parameter int CW      = 5
) (
   input  logic                               clk,
   input  logic                               reset,
   input  logic                               start,
   input  logic [1:0]                         move,
   input  logic [0:FIELD_W*FIELD_H-1]         field,
   input  logic [0:BLK*BLK-1]                 block,
   input  logic [CW-1:0]                      old_x,
   input  logic [CW-1:0]                      old_y,
   output logic                               busy,
   output logic                               done,
   output logic                               collide,
   output logic                               bottom_touch,
   output logic [$clog2(BLK+1)-1:0]           lines_cleared,
   output logic [CW-1:0]                      new_x,
   output logic [CW-1:0]                      new_y,
   output logic [0:FIELD_W*FIELD_H-1]         new_field,
   output logic [15:0]                        score_total
);

   localparam int N  = FIELD_W * FIELD_H;
   localparam int LW = $clog2(BLK + 1);
   localparam int RW = $clog2(FIELD_H + 1);

   typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MERGE, S_CLEAR, S_FILL, S_DONE} state_t;
   localparam logic [1:0] MV_DOWN = 2'b00;
   localparam logic [1:0] MV_LEFT = 2'b01;
   localparam logic [1:0] MV_RIGHT = 2'b10;

   state_t              state_q, state_d;
   logic [1:0]          move_q, move_d;
   logic [0:N-1]        field_q, field_d;
   logic [0:BLK*BLK-1]  block_q, block_d;
   logic [CW-1:0]       ox_q, ox_d, oy_q, oy_d;
   logic [CW:0]         tx_q, tx_d, ty_q, ty_d;
   logic [LW-1:0]       row_q, row_d;
   logic [RW-1:0]       rd_q, rd_d, keep_q, keep_d;
   logic                hit_q, hit_d;
   logic                collide_q, collide_d, bottom_q, bottom_d;
   logic [LW-1:0]       lines_q, lines_d;
   logic [CW-1:0]       nx_q, nx_d, ny_q, ny_d;
   logic [0:N-1]        nf_q, nf_d;
   logic                row_hit, last_row, any_hit;

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= S_IDLE;
      // NOTE: sequential state always uses non-blocking assignment so every flop samples pre-edge values.
      else       state_q <= state_d;
   end

   // Collision test of the current piece row at the target position
   always_comb begin
      int cx, cy;
      cx = 0;
      cy = 0;
      row_hit = 1'b0;
      for (int c = 0; c < BLK; c++) begin
         cx = int'(tx_q) + c;
         cy = int'(ty_q) + int'(row_q);
         if (block_q[int'(row_q)*BLK + c]) begin
            if (cx >= FIELD_W || cy >= FIELD_H) row_hit = 1'b1;
            else if (field_q[cy*FIELD_W + cx])  row_hit = 1'b1;
         end
      end
   end

   assign last_row = (row_q == LW'(BLK - 1));
   assign any_hit  = hit_q | row_hit;

   // Next-state logic
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path can infer a latch.
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (start) state_d = S_CHECK;
         S_CHECK: if (last_row) state_d = (any_hit && move_q == MV_DOWN) ? S_MERGE : S_DONE;
         S_MERGE: state_d = S_CLEAR;
         S_CLEAR: if (rd_q == '0) state_d = S_FILL;
         S_FILL:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         S_CHECK, S_MERGE, S_CLEAR, S_FILL: busy = 1'b1;
         S_DONE:                            done = 1'b1;
         default: ;
      endcase
   end

   // Datapath: work field is compacted in place; new_field only loads a finished result
   always_comb begin
      int mx, my, rd_i, wr_i;
      mx = 0;
      my = 0;
      rd_i = int'(rd_q);
      wr_i = int'(keep_q) - 1;
      move_d = move_q;   field_d = field_q;  block_d = block_q;
      ox_d = ox_q;       oy_d = oy_q;        tx_d = tx_q;      ty_d = ty_q;
      row_d = row_q;     rd_d = rd_q;        keep_d = keep_q;  hit_d = hit_q;
      collide_d = collide_q; bottom_d = bottom_q; lines_d = lines_q;
      nx_d = nx_q;       ny_d = ny_q;        nf_d = nf_q;
      unique case (state_q)
         S_IDLE: if (start) begin
            move_d = move;  field_d = field;  block_d = block;
            ox_d = old_x;   oy_d = old_y;
            tx_d = {1'b0, old_x};
            ty_d = {1'b0, old_y};
            unique case (move)
               MV_DOWN:  ty_d = {1'b0, old_y} + (CW+1)'(1);
               MV_LEFT:  tx_d = {1'b0, old_x} - (CW+1)'(1);
               MV_RIGHT: tx_d = {1'b0, old_x} + (CW+1)'(1);
               default: ;
            endcase
            row_d = '0;
            hit_d = (move == MV_LEFT) && (old_x == '0);
            collide_d = 1'b0;
            bottom_d  = 1'b0;
            lines_d   = '0;
         end
         S_CHECK: begin
            row_d = row_q + LW'(1);
            hit_d = any_hit;
            if (last_row) begin
               collide_d = any_hit;
               rd_d      = RW'(FIELD_H - 1);
               keep_d    = RW'(FIELD_H);
               if (any_hit) begin
                  nx_d = ox_q;
                  ny_d = oy_q;
                  bottom_d = (move_q == MV_DOWN);
               end else begin
                  nx_d = tx_q[CW-1:0];
                  ny_d = ty_q[CW-1:0];
               end
               if (!(any_hit && move_q == MV_DOWN)) nf_d = field_q;
            end
         end
         S_MERGE: begin
            for (int r = 0; r < BLK; r++) begin
               for (int c = 0; c < BLK; c++) begin
                  mx = int'(ox_q) + c;
                  my = int'(oy_q) + r;
                  if (block_q[r*BLK + c] && mx < FIELD_W && my < FIELD_H)
                     field_d[my*FIELD_W + mx] = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            rd_d = rd_q - RW'(1);
            if (&field_q[rd_i*FIELD_W +: FIELD_W]) begin
               lines_d = lines_q + LW'(1);
            end else begin
               field_d[wr_i*FIELD_W +: FIELD_W] = field_q[rd_i*FIELD_W +: FIELD_W];
               keep_d = keep_q - RW'(1);
            end
         end
         S_FILL: begin
            for (int y = 0; y < FIELD_H; y++)
               if (y < int'(keep_q)) field_d[y*FIELD_W +: FIELD_W] = '0;
            nf_d = field_d;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         move_q <= '0;  block_q <= '0;
         // NOTE: the wide field registers are reset too, so an aborted merge never leaks onto new_field.
         field_q <= '0; nf_q <= '0;
         ox_q <= '0;    oy_q <= '0;    tx_q <= '0;    ty_q <= '0;
         row_q <= '0;   rd_q <= '0;    keep_q <= '0;  hit_q <= 1'b0;
         collide_q <= 1'b0; bottom_q <= 1'b0; lines_q <= '0;
         nx_q <= '0;    ny_q <= '0;
      end else begin
         move_q <= move_d;  block_q <= block_d;
         field_q <= field_d; nf_q <= nf_d;
         ox_q <= ox_d;      oy_q <= oy_d;    tx_q <= tx_d;    ty_q <= ty_d;
         row_q <= row_d;    rd_q <= rd_d;    keep_q <= keep_d; hit_q <= hit_d;
         collide_q <= collide_d; bottom_q <= bottom_d; lines_q <= lines_d;
         nx_q <= nx_d;      ny_q <= ny_d;
      end
   end

`ifdef SCORE_ACC_EN
   logic [15:0] score_q, score_d;
   logic [16:0] score_sum;

   // Saturating accumulate once per completed move
   always_comb begin
      score_sum = {1'b0, score_q} + 17'(lines_q);
      score_d   = score_q;
      if (state_q == S_DONE) score_d = score_sum[16] ? 16'hFFFF : score_sum[15:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) score_q <= '0;
      else       score_q <= score_d;
   end

   assign score_total = score_q;
`else
   assign score_total = '0;
`endif

   assign collide       = collide_q;
   assign bottom_touch  = bottom_q;
   assign lines_cleared = lines_q;
   assign new_x         = nx_q;
   assign new_y         = ny_q;
   assign new_field     = nf_q;

endmodule
